shift_unit_arbiter: RTL and testbench
=====================================

Name: shift_unit_arbiter

Overview:
- Shares one combinational 32-bit shift-left unit between two requesters: ALU issue port (req0) and microcode sequencer (req1).
- Arbitrates round-robin, registers the granted operands and drives them onto the shifter.
- Captures the shifter result into a response register and holds it under a valid/ready handshake until the owning requester takes it.
- Sits between the requesters and the shifter; the shifter instance stays purely combinational and outside this block.

Parameters:
- WIDTH, 32, operand/result width; fixed at 32 to match the shifter, other values unsupported.
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand to shift.
- req0_b  in  WIDTH  requester 0 shift amount (full 32 bits).
- req1_valid  in  1  requester 1 has an operation.
- req1_ready  out  1  requester 1 operation accepted this cycle.
- req1_a  in  WIDTH  requester 1 operand.
- req1_b  in  WIDTH  requester 1 shift amount.
- sh_a  out  WIDTH  operand to shared shifter.
- sh_b  out  WIDTH  shift amount to shared shifter.
- sh_out  in  WIDTH  shifter result (combinational from sh_a/sh_b).
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 takes result.
- rsp1_valid  out  1  result for requester 1 available.
- rsp1_ready  in  1  requester 1 takes result.
- rsp_data  out  WIDTH  registered result, valid with either rspN_valid.
- busy  out  1  high in any state except IDLE.
- op_count  out  CNT_W  completed response handshakes, wraps modulo 2^CNT_W.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset goes to IDLE.
- Reset values: state IDLE, rr_ptr 0, gnt_id 0, op registers 0 (so sh_a = sh_b = 0), rsp_data 0, all ready/valid outputs 0, busy 0, op_count 0.
- Grant in IDLE:
  - Only one reqN_valid high: that requester is granted.
  - Both high: requester rr_ptr is granted.
  - reqN_ready = (state==IDLE) & reqN_valid & granted N; never both high; combinational from the valids.
- Accept (IDLE with a ready high):
  - Latch a/b of the granted requester into op registers; gnt_id <= granted index; rr_ptr <= ~granted index.
  - state -> EXEC.
  - No accept means the state stays IDLE and rr_ptr is unchanged.
- EXEC (exactly 1 cycle):
  - sh_a/sh_b show the latched operands.
  - rsp_data <= sh_out; state -> RESP.
  - The block does no arithmetic; b >= 32 yields 0 purely via the shifter.
- RESP:
  - rsp{gnt_id}_valid = 1; the other rspN_valid = 0.
  - rsp_data and op registers are held stable.
  - On rsp{gnt_id}_ready: op_count += 1 (wraps) and state -> IDLE.
  - rspN_ready of the non-granted requester is ignored.
- Latency and throughput:
  - Accept at cycle T: rsp valid at T+2.
  - Minimum issue interval is 3 cycles.
  - No new request is accepted in EXEC or RESP; requesters must hold valid/a/b stable until ready.
- sh_a/sh_b are driven only from the op registers, never combinationally from request ports.
- Reset mid-operation (EXEC or RESP):
  - In-flight operation is dropped with no response.
  - All registers take reset values on the next edge; op_count is cleared.
- Back-pressure in RESP: rsp_ready low for any number of cycles keeps rsp_data and valid unchanged.
- Arbitration is fair: with both requesters continuously valid, grants alternate 0,1,0,1…

Test Plan:
1. req0 only, a=0x0000_0001, b=4 -> req0_ready in accept cycle T, rsp0_valid at T+2 with rsp_data=0x0000_0010, rsp1_valid=0, op_count=1 after the handshake.
2. req1 only, a=0xFFFF_FFFF, b=0x0000_0020 (32) -> rsp1_valid with rsp_data=0x0000_0000; then b=31 -> rsp_data=0x8000_0000.
3. Both valid continuously from reset, req0 a=0x3/b=1, req1 a=0x5/b=2 -> grants alternate req0, req1, req0; results 0x6, 0x14, 0x6; never both readies high; op_count=3.
4. Back-pressure: rsp0_ready held low 5 cycles after rsp0_valid; req1_valid high throughout -> rsp_data stable, busy=1, req1_ready=0 until the handshake; req1 accepted in the first IDLE cycle afterwards.
5. Reset asserted during EXEC, then during RESP -> next cycle state IDLE, rspN_valid=0, rsp_data=0, sh_a=sh_b=0, op_count=0; no stale response appears after reset deasserts.
6. op_count wrap: force 2^CNT_W completions with CNT_W=4 (16 ops) -> op_count returns to 0 after the 16th handshake.

Source files
------------

// File: rtl/shift_unit_arbiter_if.sv
// Request, shifter and response signals of the shared shift-unit arbiter.
// The slave modport is the arbiter's view; master is the requester/shifter side.
interface shift_unit_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_out;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  sh_out, rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, sh_a, sh_b,
        output rsp0_valid, rsp1_valid, rsp_data, busy, op_count
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output sh_out, rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, sh_a, sh_b,
        input  rsp0_valid, rsp1_valid, rsp_data, busy, op_count
    );
endinterface

// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one external combinational shift-left unit
// between two requesters, with a held valid/ready response register.
module shift_unit_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               reset,
    shift_unit_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q,      state_d;
    logic             rr_ptr_q,     rr_ptr_d;
    logic             gnt_id_q,     gnt_id_d;
    logic [WIDTH-1:0] op_a_q,       op_a_d;
    logic [WIDTH-1:0] op_b_q,       op_b_d;
    logic [WIDTH-1:0] rsp_data_q,   rsp_data_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic             busy_q,       busy_d;
    logic [CNT_W-1:0] op_count_q,   op_count_d;

    logic gnt_sel_s;
    logic accept_s;
    logic rsp_take_s;

    // Pick the requester to serve: a lone valid wins, a tie goes to rr_ptr.
    always_comb begin
        gnt_sel_s = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            gnt_sel_s = rr_ptr_q;
        end else if (bus.req1_valid) begin
            gnt_sel_s = 1'b1;
        end else begin
            gnt_sel_s = 1'b0;
        end
    end

    assign accept_s   = (state_q == ST_IDLE) && (bus.req0_valid || bus.req1_valid);
    assign rsp_take_s = gnt_id_q ? bus.rsp1_ready : bus.rsp0_ready;

    // Next-state and next-register values for the whole block.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_id_d     = gnt_id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rsp_data_d   = rsp_data_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        op_count_d   = op_count_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    op_a_d   = gnt_sel_s ? bus.req1_a : bus.req0_a;
                    op_b_d   = gnt_sel_s ? bus.req1_b : bus.req0_b;
                    gnt_id_d = gnt_sel_s;
                    rr_ptr_d = ~gnt_sel_s;
                    state_d  = ST_EXEC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_EXEC: begin
                rsp_data_d   = bus.sh_out;
                rsp0_valid_d = ~gnt_id_q;
                rsp1_valid_d = gnt_id_q;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_take_s) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    op_count_d   = op_count_q + CNT_W'(1);
                    state_d      = ST_IDLE;
                end else begin
                    state_d      = ST_RESP;
                end
            end
            default: begin
                rsp0_valid_d = 1'b0;
                rsp1_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State register; reset drops any in-flight operation without a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= 1'b0;
            gnt_id_q     <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rsp_data_q   <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_id_q     <= gnt_id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rsp_data_q   <= rsp_data_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            busy_q       <= busy_d;
            op_count_q   <= op_count_d;
        end
    end

    // Request readies must react in the accept cycle, so they stay combinational.
    assign bus.req0_ready = accept_s && !gnt_sel_s;
    assign bus.req1_ready = accept_s && gnt_sel_s;
    assign bus.sh_a       = op_a_q;
    assign bus.sh_b       = op_b_q;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.busy       = busy_q;
    assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed bench for shift_unit_arbiter with an expected-result scoreboard.
// The external shifter is modelled here as a combinational shift-left.
module tb_shift_unit_arbiter;

    logic clk;
    logic reset;

    shift_unit_arbiter_if #(.WIDTH(32), .CNT_W(4)) bus ();

    shift_unit_arbiter #(.WIDTH(32), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_asserts = 0;
    int   n_fail    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] shl(input logic [31:0] a, input logic [31:0] b);
        return (b >= 32'd32) ? 32'd0 : (a << b[4:0]);
    endfunction

    assign bus.sh_out = shl(bus.sh_a, bus.sh_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic v, input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic wait_accept(input int id);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if ((id == 0 && bus.req0_ready) || (id == 1 && bus.req1_ready)) ok = 1'b1;
            step();
        end
        set_req(id, 1'b0, 32'd0, 32'd0);
        n_asserts++;
        assert (ok) else begin
            n_fail++;
            $error("FAIL accept_timeout: observed no ready for req%0d expected ready within 20 cycles", id);
        end
    endtask

    task automatic take_rsp(input int id);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if ((id == 0 && bus.rsp0_valid) || (id == 1 && bus.rsp1_valid)) begin
                ok = 1'b1;
                if (id == 0) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
            end
            step();
            bus.rsp0_ready = 1'b0;
            bus.rsp1_ready = 1'b0;
        end
        n_asserts++;
        assert (ok) else begin
            n_fail++;
            $error("FAIL rsp_timeout: observed no rsp%0d_valid expected valid within 20 cycles", id);
        end
    endtask

    task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b);
        set_req(id, 1'b1, a, b);
        wait_accept(id);
        take_rsp(id);
    endtask

    // Monitor: record accepted operations and check each completed response.
    always @(negedge clk) begin
        if (!reset) begin
            check("ready_excl", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            check("rsp_valid_excl", 32'(bus.rsp0_valid & bus.rsp1_valid), 32'd0);
            if (bus.req0_ready) sb.push_back({1'b0, shl(bus.req0_a, bus.req0_b)});
            else if (bus.req1_ready) sb.push_back({1'b1, shl(bus.req1_a, bus.req1_b)});
            if ((bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready)) begin
                n_asserts++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_rsp: observed response 0x%08h expected none", bus.rsp_data);
                end
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("rsp_owner", 32'(bus.rsp1_valid), 32'(mon_e.id));
                    check("rsp_data", bus.rsp_data, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gseq[3];
        int ng;
        reset = 1'b1;
        set_req(0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 32'd0, 32'd0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        step(); step();
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_sh_a", bus.sh_a, 32'd0);
        check("rst_sh_b", bus.sh_b, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_op_count", 32'(bus.op_count), 32'd0);
        check("rst_rsp_valid", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
        reset = 1'b0;
        #1;
        check("idle_readies", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);

        // Single req0 with exact cycle timing.
        set_req(0, 1'b1, 32'h0000_0001, 32'd4);
        #1;
        check("t1_req0_ready", 32'(bus.req0_ready), 32'd1);
        check("t1_req1_ready", 32'(bus.req1_ready), 32'd0);
        step();
        set_req(0, 1'b0, 32'd0, 32'd0);
        check("t1_exec_busy", 32'(bus.busy), 32'd1);
        check("t1_exec_sh_a", bus.sh_a, 32'h0000_0001);
        check("t1_exec_sh_b", bus.sh_b, 32'd4);
        check("t1_exec_rsp0", 32'(bus.rsp0_valid), 32'd0);
        step();
        check("t1_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        check("t1_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        check("t1_rsp_data", bus.rsp_data, 32'h0000_0010);
        bus.rsp0_ready = 1'b1;
        step();
        bus.rsp0_ready = 1'b0;
        check("t1_op_count", 32'(bus.op_count), 32'd1);
        check("t1_idle_busy", 32'(bus.busy), 32'd0);

        // req1 with shift amounts at and just below the width.
        do_op(1, 32'hFFFF_FFFF, 32'd32);
        do_op(1, 32'hFFFF_FFFF, 32'd31);
        check("t2_op_count", 32'(bus.op_count), 32'd3);

        // Both requesters continuously valid from reset: fair alternation.
        reset = 1'b1;
        set_req(0, 1'b1, 32'h3, 32'd1);
        set_req(1, 1'b1, 32'h5, 32'd2);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        ng = 0;
        for (int i = 0; i < 9; i++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                if (ng < 3) gseq[ng] = bus.req1_ready ? 1 : 0;
                ng++;
            end
            step();
        end
        set_req(0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 32'd0, 32'd0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        check("t3_grant_count", 32'(ng), 32'd3);
        check("t3_grant0", 32'(gseq[0]), 32'd0);
        check("t3_grant1", 32'(gseq[1]), 32'd1);
        check("t3_grant2", 32'(gseq[2]), 32'd0);
        check("t3_op_count", 32'(bus.op_count), 32'd3);

        // Back-pressure on rsp0 while req1 waits.
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_req(1, 1'b1, 32'h2, 32'd5);
        set_req(0, 1'b1, 32'h7, 32'd3);
        #1;
        check("t4_req0_ready", 32'(bus.req0_ready), 32'd1);
        check("t4_req1_ready", 32'(bus.req1_ready), 32'd0);
        step();
        set_req(0, 1'b0, 32'd0, 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", 32'(bus.rsp0_valid), 32'd1);
            check("t4_hold_data", bus.rsp_data, 32'h0000_0038);
            check("t4_hold_busy", 32'(bus.busy), 32'd1);
            check("t4_hold_req1_ready", 32'(bus.req1_ready), 32'd0);
            step();
        end
        bus.rsp0_ready = 1'b1;
        #1;
        check("t4_take_req1_ready", 32'(bus.req1_ready), 32'd0);
        step();
        bus.rsp0_ready = 1'b0;
        #1;
        check("t4_first_idle_req1_ready", 32'(bus.req1_ready), 32'd1);
        wait_accept(1);
        take_rsp(1);
        check("t4_op_count", 32'(bus.op_count), 32'd2);

        // Reset during EXEC.
        do_op(0, 32'h9, 32'd1);
        set_req(0, 1'b1, 32'h9, 32'd2);
        wait_accept(0);
        check("t5_exec_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        check("t5e_busy", 32'(bus.busy), 32'd0);
        check("t5e_rsp_valid", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
        check("t5e_rsp_data", bus.rsp_data, 32'd0);
        check("t5e_sh_a", bus.sh_a, 32'd0);
        check("t5e_sh_b", bus.sh_b, 32'd0);
        check("t5e_op_count", 32'(bus.op_count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("t5e_no_stale", 32'({bus.rsp0_valid, bus.rsp1_valid, bus.busy}), 32'd0);
            step();
        end

        // Reset during RESP.
        set_req(1, 1'b1, 32'h3, 32'd4);
        wait_accept(1);
        step();
        check("t5r_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        check("t5r_rsp_valid", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
        check("t5r_rsp_data", bus.rsp_data, 32'd0);
        check("t5r_sh_a", bus.sh_a, 32'd0);
        check("t5r_sh_b", bus.sh_b, 32'd0);
        check("t5r_op_count", 32'(bus.op_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("t5r_no_stale", 32'({bus.rsp0_valid, bus.rsp1_valid, bus.busy}), 32'd0);
            step();
        end

        // Counter wrap with a 4-bit op_count.
        for (int i = 0; i < 16; i++) begin
            do_op(i % 2, $urandom(), 32'($urandom_range(40, 0)));
            if (i == 0)  check("t6_count_first", 32'(bus.op_count), 32'd1);
            if (i == 14) check("t6_count_15", 32'(bus.op_count), 32'd15);
        end
        check("t6_count_wrap", 32'(bus.op_count), 32'd0);

        step();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
